// File: rtl/seq_mlp_pkg.sv
// seq_mlp_pkg: shared types and default model for the time-multiplexed MLP classifier.
//   wcode_t   - weight code {zero, sign, shift}; value is 0 or +/-2^shift
//   state_e   - engine FSM states
//   mac_op_e  - operation selector for the shared shift-add MAC
//   DefW0/DefB0/DefW1/DefB1 - default model constants
//   latency() - accept-edge to out_valid latency in cycles
package seq_mlp_pkg;

   localparam int unsigned SHIFT_W = 4;

   typedef struct packed {
      logic               zero;
      logic               sign;
      logic [SHIFT_W-1:0] shift;
   } wcode_t;

   typedef enum logic [2:0] {
      StIdle,
      StBias,
      StMac,
      StAct,
      StArgmax,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      MacPass,
      MacAdd,
      MacReluHid,
      MacReluOut
   } mac_op_e;

   localparam int unsigned DefNIn  = 8;
   localparam int unsigned DefNHid = 3;
   localparam int unsigned DefNOut = 3;
   localparam int unsigned DefAccW = 18;

   // An all-zero code is +2^0, so '0 gives an all-(+1) weight table.
   localparam wcode_t [DefNHid-1:0][DefNIn-1:0]  DefW0 = '0;
   localparam wcode_t [DefNOut-1:0][DefNHid-1:0] DefW1 = '0;
   localparam logic [DefNHid-1:0][DefAccW-1:0]   DefB0 = '0;
   localparam logic [DefNOut-1:0][DefAccW-1:0]   DefB1 = '0;

   function automatic int unsigned latency(input int unsigned n_in, input int unsigned n_hid,
                                           input int unsigned n_out);
      return n_hid * (n_in + 2) + n_out * (n_hid + 2) + n_out + 1;
   endfunction

endpackage

// File: rtl/seq_mlp_argmax_if.sv
// seq_mlp_argmax_if: valid/ready framing for one input vector in and one class result out.
//   master - producer/consumer side: drives in_valid, in_data, out_ready
//   slave  - engine side: drives in_ready, out_valid, out_class, out_score
interface seq_mlp_argmax_if #(
   parameter int unsigned N_IN  = 8,
   parameter int unsigned IN_W  = 4,
   parameter int unsigned N_OUT = 3,
   parameter int unsigned ACC_W = 18
);
   logic                     in_valid;
   logic                     in_ready;
   logic [N_IN*IN_W-1:0]     in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [$clog2(N_OUT)-1:0] out_class;
   logic [ACC_W-1:0]         out_score;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_class, out_score
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_class, out_score
   );
endinterface

// File: rtl/seq_mlp_mac.sv
// seq_mlp_mac: combinational shift-add accumulate step plus ReLU / quantise.
//   op_i      - MacPass (hold), MacAdd (acc +/- operand<<shift),
//               MacReluHid (clamp(acc>>FRAC_SH) to HID_W bits), MacReluOut (max(acc,0))
//   sign_i    - subtract instead of add
//   shift_i   - power-of-two weight exponent
//   operand_i - unsigned activation
//   acc_i     - current two's-complement accumulator
//   acc_o     - next accumulator / activation value
module seq_mlp_mac
   import seq_mlp_pkg::*;
#(
   parameter int unsigned ACC_W   = 18,
   parameter int unsigned OP_W    = 8,
   parameter int unsigned HID_W   = 8,
   parameter int unsigned FRAC_SH = 3
) (
   input  mac_op_e            op_i,
   input  logic               sign_i,
   input  logic [SHIFT_W-1:0] shift_i,
   input  logic [OP_W-1:0]    operand_i,
   input  logic [ACC_W-1:0]   acc_i,
   output logic [ACC_W-1:0]   acc_o
);

   localparam logic [ACC_W-1:0] HidMax = ACC_W'((1 << HID_W) - 1);

   logic [ACC_W-1:0] term;
   logic [ACC_W-1:0] quant;

   always_comb begin
      term  = ACC_W'(operand_i) << shift_i;
      // Only used when acc_i is non-negative, so a logical shift is exact.
      quant = acc_i >> FRAC_SH;
      if (quant > HidMax) begin
         quant = HidMax;
      end
      acc_o = acc_i;
      unique case (op_i)
         MacPass:    acc_o = acc_i;
         MacAdd:     acc_o = sign_i ? (acc_i - term) : (acc_i + term);
         MacReluHid: acc_o = acc_i[ACC_W-1] ? '0 : quant;
         MacReluOut: acc_o = acc_i[ACC_W-1] ? '0 : acc_i;
         default:    acc_o = acc_i;
      endcase
   end

endmodule

// File: rtl/seq_mlp_argmax.sv
// seq_mlp_argmax: time-multiplexed two-layer MLP classifier with argmax output.
// One shared shift-add MAC evaluates every neuron term by term; a valid/ready handshake frames
// one input vector in and one (class, score) result out.
//   clk   - clock
//   rst_n - synchronous active-low reset
//   bus   - seq_mlp_argmax_if.slave: in_valid/in_ready/in_data, out_valid/out_ready/
//           out_class/out_score
// Build option: define APPROX_ARGMAX_EN to compare only (y & ARGMAX_MASK) in the argmax;
// out_score always carries the full value of the selected neuron.
module seq_mlp_argmax
   import seq_mlp_pkg::*;
#(
   parameter int unsigned N_IN        = DefNIn,
   parameter int unsigned IN_W        = 4,
   parameter int unsigned N_HID       = DefNHid,
   parameter int unsigned N_OUT       = DefNOut,
   parameter int unsigned HID_W       = 8,
   parameter int unsigned ACC_W       = DefAccW,
   parameter int unsigned FRAC_SH     = 3,
   parameter logic [ACC_W-1:0] ARGMAX_MASK = ACC_W'(16'h0500),
   parameter wcode_t [N_HID-1:0][N_IN-1:0]  W0 = DefW0,
   parameter wcode_t [N_OUT-1:0][N_HID-1:0] W1 = DefW1,
   parameter logic [N_HID-1:0][ACC_W-1:0]   B0 = DefB0,
   parameter logic [N_OUT-1:0][ACC_W-1:0]   B1 = DefB1
) (
   input logic              clk,
   input logic              rst_n,
   seq_mlp_argmax_if.slave  bus
);

   localparam int unsigned MaxN = (N_IN > N_HID) ? ((N_IN > N_OUT) ? N_IN : N_OUT)
                                                 : ((N_HID > N_OUT) ? N_HID : N_OUT);
   localparam int unsigned CntW = (MaxN > 1) ? $clog2(MaxN) : 1;
   localparam int unsigned ClsW = $clog2(N_OUT);
   localparam int unsigned OpW  = (IN_W > HID_W) ? IN_W : HID_W;

   // Worst-case accumulator magnitude for each layer given the actual weight table.
   function automatic longint worst_l0();
      longint worst, sum, b;
      worst = 0;
      for (int n = 0; n < N_HID; n++) begin
         b   = longint'(signed'(B0[n]));
         sum = (b < 0) ? -b : b;
         for (int k = 0; k < N_IN; k++) begin
            if (!W0[n][k].zero) begin
               sum = sum + (longint'((1 << IN_W) - 1) << W0[n][k].shift);
            end
         end
         if (sum > worst) worst = sum;
      end
      return worst;
   endfunction

   function automatic longint worst_l1();
      longint worst, sum, b;
      worst = 0;
      for (int n = 0; n < N_OUT; n++) begin
         b   = longint'(signed'(B1[n]));
         sum = (b < 0) ? -b : b;
         for (int k = 0; k < N_HID; k++) begin
            if (!W1[n][k].zero) begin
               sum = sum + (longint'((1 << HID_W) - 1) << W1[n][k].shift);
            end
         end
         if (sum > worst) worst = sum;
      end
      return worst;
   endfunction

   localparam longint AccLimit = longint'(1) << (ACC_W - 1);

   if (worst_l0() >= AccLimit || worst_l1() >= AccLimit) begin : g_acc_too_narrow
      $fatal(1, "seq_mlp_argmax: ACC_W too narrow for the configured weights and biases");
   end

   state_e                        state_q;
   logic [N_IN*IN_W-1:0]          x_q;
   logic                          layer_q;
   logic [CntW-1:0]               neuron_q;
   logic [CntW-1:0]               k_q;
   logic [ACC_W-1:0]              acc_q;
   logic [N_HID-1:0][HID_W-1:0]   hid_q;
   logic [N_OUT-1:0][ACC_W-1:0]   y_q;
   logic [ClsW-1:0]               best_idx_q;
   logic [ACC_W-1:0]              best_score_q;
   logic                          in_ready_q;
   logic                          out_valid_q;
   logic [ClsW-1:0]               out_class_q;
   logic [ACC_W-1:0]              out_score_q;

   wcode_t           w_sel;
   logic [OpW-1:0]   x_sel;
   logic [ACC_W-1:0] bias_sel;
   logic [ACC_W-1:0] y_sel;
   logic [ACC_W-1:0] cand_key;
   logic [ACC_W-1:0] best_key;
   logic [CntW-1:0]  last_k;
   logic [CntW-1:0]  last_neuron;
   mac_op_e          mac_op;
   logic [ACC_W-1:0] mac_acc;

   // Operand, weight and bias selection for the current (layer, neuron, k).
   always_comb begin
      w_sel    = '0;
      x_sel    = '0;
      bias_sel = '0;
      y_sel    = '0;
      for (int n = 0; n < N_HID; n++) begin
         for (int k = 0; k < N_IN; k++) begin
            if (!layer_q && neuron_q == CntW'(n) && k_q == CntW'(k)) w_sel = W0[n][k];
         end
         if (!layer_q && neuron_q == CntW'(n)) bias_sel = B0[n];
      end
      for (int n = 0; n < N_OUT; n++) begin
         for (int k = 0; k < N_HID; k++) begin
            if (layer_q && neuron_q == CntW'(n) && k_q == CntW'(k)) w_sel = W1[n][k];
         end
         if (layer_q && neuron_q == CntW'(n)) bias_sel = B1[n];
         if (neuron_q == CntW'(n)) y_sel = y_q[n];
      end
      for (int k = 0; k < N_IN; k++) begin
         if (!layer_q && k_q == CntW'(k)) x_sel = OpW'(x_q[k*IN_W +: IN_W]);
      end
      for (int k = 0; k < N_HID; k++) begin
         if (layer_q && k_q == CntW'(k)) x_sel = OpW'(hid_q[k]);
      end
   end

   always_comb begin
      last_k      = layer_q ? CntW'(N_HID - 1) : CntW'(N_IN - 1);
      last_neuron = layer_q ? CntW'(N_OUT - 1) : CntW'(N_HID - 1);
      mac_op      = MacPass;
      if (state_q == StMac && !w_sel.zero) begin
         mac_op = MacAdd;
      end else if (state_q == StAct) begin
         mac_op = layer_q ? MacReluOut : MacReluHid;
      end
   end

`ifdef APPROX_ARGMAX_EN
   localparam logic [ACC_W-1:0] KeyMask = ARGMAX_MASK;
`else
   // All-ones: full-width comparison.
   localparam logic [ACC_W-1:0] KeyMask = ARGMAX_MASK | ~ARGMAX_MASK;
`endif

   assign cand_key = y_sel & KeyMask;
   assign best_key = best_score_q & KeyMask;

   seq_mlp_mac #(
      .ACC_W   (ACC_W),
      .OP_W    (OpW),
      .HID_W   (HID_W),
      .FRAC_SH (FRAC_SH)
   ) u_mac (
      .op_i      (mac_op),
      .sign_i    (w_sel.sign),
      .shift_i   (w_sel.shift),
      .operand_i (x_sel),
      .acc_i     (acc_q),
      .acc_o     (mac_acc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         x_q          <= '0;
         layer_q      <= 1'b0;
         neuron_q     <= '0;
         k_q          <= '0;
         acc_q        <= '0;
         hid_q        <= '0;
         y_q          <= '0;
         best_idx_q   <= '0;
         best_score_q <= '0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         out_class_q  <= '0;
         out_score_q  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid && in_ready_q) begin
                  x_q        <= bus.in_data;
                  layer_q    <= 1'b0;
                  neuron_q   <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= StBias;
               end
            end
            StBias: begin
               acc_q   <= bias_sel;
               k_q     <= '0;
               state_q <= StMac;
            end
            StMac: begin
               acc_q <= mac_acc;
               if (k_q == last_k) begin
                  state_q <= StAct;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            StAct: begin
               for (int n = 0; n < N_HID; n++) begin
                  if (!layer_q && neuron_q == CntW'(n)) hid_q[n] <= mac_acc[HID_W-1:0];
               end
               for (int n = 0; n < N_OUT; n++) begin
                  if (layer_q && neuron_q == CntW'(n)) y_q[n] <= mac_acc;
               end
               if (neuron_q == last_neuron) begin
                  neuron_q <= '0;
                  if (layer_q) begin
                     state_q <= StArgmax;
                  end else begin
                     layer_q <= 1'b1;
                     state_q <= StBias;
                  end
               end else begin
                  neuron_q <= neuron_q + 1'b1;
                  state_q  <= StBias;
               end
            end
            StArgmax: begin
               // Strictly-greater replacement keeps the lowest index on ties.
               if (neuron_q == '0 || cand_key > best_key) begin
                  best_idx_q   <= neuron_q[ClsW-1:0];
                  best_score_q <= y_sel;
               end
               if (neuron_q == CntW'(N_OUT - 1)) begin
                  state_q <= StDone;
               end else begin
                  neuron_q <= neuron_q + 1'b1;
               end
            end
            StDone: begin
               // First DONE cycle latches the winner; outputs then hold until consumed.
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_class_q <= best_idx_q;
                  out_score_q <= best_score_q;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_class = out_class_q;
   assign bus.out_score = out_score_q;

endmodule

// File: tb/tb_seq_mlp_argmax.sv
// tb_seq_mlp_argmax: directed bench for seq_mlp_argmax. Four engines with different models
// share one stimulus stream:
//   a - all weights +1, biases 0
//   b - as a, with B1 = {0,0,1}
//   c - all hidden weights -1, biases 0
//   d - W1 all zero, B1 = {0x10,0xFF,0x01}
module tb_seq_mlp_argmax;
   import seq_mlp_pkg::*;

   localparam int unsigned NIn  = 8;
   localparam int unsigned InW  = 4;
   localparam int unsigned NHid = 3;
   localparam int unsigned NOut = 3;
   localparam int unsigned AccW = 18;

   localparam logic [31:0] VecF    = 32'hFFFF_FFFF;
   localparam logic [31:0] VecRamp = 32'h7654_3210; // feature k = k

   localparam logic [NOut-1:0][AccW-1:0]   B1Tie  = {18'd1, 18'd0, 18'd0};
   localparam wcode_t [NHid-1:0][NIn-1:0]  W0Neg  = {(NHid*NIn){6'b010000}};
   localparam wcode_t [NOut-1:0][NHid-1:0] W1Zero = {(NOut*NHid){6'b100000}};
   localparam logic [NOut-1:0][AccW-1:0]   B1Mix  = {18'h00001, 18'h000FF, 18'h00010};

`ifdef APPROX_ARGMAX_EN
   localparam int unsigned DCls   = 0;
   localparam int unsigned DScore = 16;
`else
   localparam int unsigned DCls   = 1;
   localparam int unsigned DScore = 255;
`endif

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               out_ready;
   logic [NIn*InW-1:0] in_data;
   int unsigned        n_vec = 0;
   int unsigned        n_err = 0;
   int unsigned        lat;
   int unsigned        spurious;

   always #5 clk = ~clk;

   seq_mlp_argmax_if #(.N_IN(NIn), .IN_W(InW), .N_OUT(NOut), .ACC_W(AccW)) bus_a ();
   seq_mlp_argmax_if #(.N_IN(NIn), .IN_W(InW), .N_OUT(NOut), .ACC_W(AccW)) bus_b ();
   seq_mlp_argmax_if #(.N_IN(NIn), .IN_W(InW), .N_OUT(NOut), .ACC_W(AccW)) bus_c ();
   seq_mlp_argmax_if #(.N_IN(NIn), .IN_W(InW), .N_OUT(NOut), .ACC_W(AccW)) bus_d ();

   assign bus_a.in_valid = in_valid;
   assign bus_a.in_data = in_data;
   assign bus_a.out_ready = out_ready;
   assign bus_b.in_valid = in_valid;
   assign bus_b.in_data = in_data;
   assign bus_b.out_ready = out_ready;
   assign bus_c.in_valid = in_valid;
   assign bus_c.in_data = in_data;
   assign bus_c.out_ready = out_ready;
   assign bus_d.in_valid = in_valid;
   assign bus_d.in_data = in_data;
   assign bus_d.out_ready = out_ready;

   seq_mlp_argmax u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   seq_mlp_argmax #(.B1(B1Tie)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
   seq_mlp_argmax #(.W0(W0Neg)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
   seq_mlp_argmax #(.W1(W1Zero), .B1(B1Mix)) u_dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_dut(input string tag, input logic v, input logic r,
                            input logic [1:0] c, input logic [AccW-1:0] s,
                            input logic ev, input logic er,
                            input int unsigned ec, input int unsigned es);
      check_eq({tag, " out_valid"}, 32'(v), 32'(ev));
      check_eq({tag, " in_ready"}, 32'(r), 32'(er));
      check_eq({tag, " out_class"}, 32'(c), ec);
      check_eq({tag, " out_score"}, 32'(s), es);
   endtask

   task automatic check_reset_all(input string tag);
      check_dut({tag, " a"}, bus_a.out_valid, bus_a.in_ready, bus_a.out_class, bus_a.out_score,
                1'b0, 1'b1, 0, 0);
      check_dut({tag, " b"}, bus_b.out_valid, bus_b.in_ready, bus_b.out_class, bus_b.out_score,
                1'b0, 1'b1, 0, 0);
      check_dut({tag, " c"}, bus_c.out_valid, bus_c.in_ready, bus_c.out_class, bus_c.out_score,
                1'b0, 1'b1, 0, 0);
      check_dut({tag, " d"}, bus_d.out_valid, bus_d.in_ready, bus_d.out_class, bus_d.out_score,
                1'b0, 1'b1, 0, 0);
   endtask

   task automatic check_result_all(input string tag, input int unsigned ca, input int unsigned sa,
                                   input int unsigned cb, input int unsigned sb);
      check_dut({tag, " a"}, bus_a.out_valid, bus_a.in_ready, bus_a.out_class, bus_a.out_score,
                1'b1, 1'b0, ca, sa);
      check_dut({tag, " b"}, bus_b.out_valid, bus_b.in_ready, bus_b.out_class, bus_b.out_score,
                1'b1, 1'b0, cb, sb);
      check_dut({tag, " c"}, bus_c.out_valid, bus_c.in_ready, bus_c.out_class, bus_c.out_score,
                1'b1, 1'b0, 0, 0);
      check_dut({tag, " d"}, bus_d.out_valid, bus_d.in_ready, bus_d.out_class, bus_d.out_score,
                1'b1, 1'b0, DCls, DScore);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a vector for one edge, then scramble in_data to show it is not re-sampled.
   task automatic send(input string tag, input logic [31:0] data);
      check_eq({tag, " in_ready before accept"}, 32'(bus_a.in_ready), 1);
      in_data  = data;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_data  = ~data;
      check_eq({tag, " in_ready after accept"}, 32'(bus_a.in_ready), 0);
   endtask

   // Edges after the accepting edge until out_valid rises; 200 means it never did.
   task automatic wait_valid(output int unsigned n);
      n = 0;
      while (!bus_a.out_valid && n < 200) begin
         step();
         n++;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      step();
      step();
      check_reset_all("reset");
      rst_n = 1'b1;
      step();

      // All-0xF input: hidden 120>>3 = 15, outputs 45 (b: 46 on class 2).
      send("vecF", VecF);
      wait_valid(lat);
      check_eq("vecF latency", lat, 49);
      check_result_all("vecF", 0, 45, 2, 46);

      // Back-pressure: result must hold while out_ready stays low.
      for (int i = 0; i < 20; i++) begin
         step();
         check_dut("hold a", bus_a.out_valid, bus_a.in_ready, bus_a.out_class, bus_a.out_score,
                   1'b1, 1'b0, 0, 45);
         check_eq("hold b out_class", 32'(bus_b.out_class), 2);
      end

      // Consume with a new vector already offered; it must not be taken in the same edge.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = VecRamp;
      step();
      out_ready = 1'b0;
      check_eq("consume out_valid", 32'(bus_a.out_valid), 0);
      check_eq("consume in_ready", 32'(bus_a.in_ready), 1);
      step();
      in_valid = 1'b0;
      in_data  = VecF;
      check_eq("back-to-back accepted", 32'(bus_a.in_ready), 0);
      // Ramp input: hidden 28>>3 = 3, outputs 9 (b: 10 on class 2).
      wait_valid(lat);
      check_eq("ramp latency", lat, 49);
      check_result_all("ramp", 0, 9, 2, 10);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Abort a computation with reset partway through.
      send("abort", VecF);
      repeat (19) step();
      rst_n = 1'b0;
      step();
      check_reset_all("mid reset");
      rst_n    = 1'b1;
      spurious = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (bus_a.out_valid || bus_b.out_valid || bus_c.out_valid || bus_d.out_valid) begin
            spurious++;
         end
      end
      check_eq("no output after abort", spurious, 0);

      send("post-reset", VecRamp);
      wait_valid(lat);
      check_eq("post-reset latency", lat, 49);
      check_result_all("post-reset", 0, 9, 2, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_mlp_argmax.md
# seq_mlp_argmax

Parametrised, time-multiplexed two-layer MLP classifier with argmax output for the printed-MLP fault-analysis designs. It replaces the fully unrolled combinational network with a single shared shift-add MAC, which trades latency for area. A valid/ready handshake frames one input vector in and one class index out. It is the next-generation engine for the larger benchmark networks and is instantiated by the per-dataset top levels.

## Interface
- N_IN, 8, input features
- IN_W, 4, bits per feature (unsigned)
- N_HID, 3, hidden neurons
- N_OUT, 3, output classes
- HID_W, 8, hidden activation width after quantised ReLU
- ACC_W, 18, signed accumulator width
- FRAC_SH, 3, right shift applied in hidden quantised ReLU
- ARGMAX_MASK, 16'h0500, bit mask used by the approximate argmax
- W0, W1, B0, B1, package model constants; weight/bias tables (encoding in Operation)
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  engine can accept a vector
- in_data  in  N_IN*IN_W  features; feature i at [i*IN_W +: IN_W]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_class  out  $clog2(N_OUT)  winning class index
- out_score  out  ACC_W  winning output-neuron value (post-ReLU)

## Operation
- Weight encoding: {zero, sign, shift[3:0]}; value = 0, or ±2^shift. The product is a shift, never a multiply. Biases are signed ACC_W integers in the accumulator scale.
- FSM states: IDLE, BIAS, MAC, ACT, ARGMAX, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, register in_data, set layer=0, neuron=0, go to BIAS.
- BIAS: acc <= bias[layer][neuron]; input index k <= 0.
- MAC: acc <= acc ± (x_k << shift), or acc unchanged if zero. One term per cycle; k counts 0..fan_in-1. fan_in is N_IN for layer 0 and N_HID for layer 1.
- ACT, layer 0: h = acc<0 ? 0 : min(acc>>FRAC_SH, 2^HID_W-1). Write h into the hidden register file.
- ACT, layer 1: y = acc<0 ? 0 : acc. Write y into the output register file.
- After ACT, advance to the next neuron (BIAS). After the last neuron of layer 0, go to layer 1. After layer 1, go to ARGMAX.
- ARGMAX: one output per cycle. The incumbent is replaced only if the candidate is strictly greater, so ties keep the lower index. Then go to DONE.
- DONE: out_valid=1. out_class and out_score are held stable until out_valid&out_ready, then return to IDLE.
- Accumulator arithmetic is two's-complement, ACC_W bits, no saturation. ACC_W must cover the worst-case sum; this is an elaboration-time assertion.

## Timing
- Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=1 after reset, out_valid=0, out_class=0, out_score=0, all register files cleared. Reset mid-computation abandons the vector; no output is produced.
- Latency from the accepting edge to out_valid=1 is N_HID*(N_IN+2) + N_OUT*(N_HID+2) + N_OUT + 1 cycles. With defaults this is 30+15+3+1 = 49.
- in_ready=0 in every state except IDLE. The engine never accepts a new vector in the same cycle a result is consumed.
- in_data is sampled only at the accepting edge. Later changes to in_data are ignored.
- Back-pressure: DONE holds indefinitely while out_ready=0.

## Configuration
- APPROX_ARGMAX_EN defined: the argmax compares (y & ARGMAX_MASK) only. This gives a reduced comparator matching the approximate-argmax designs.
- APPROX_ARGMAX_EN undefined: full ACC_W-bit comparison.
- In both cases out_score is the full value of the selected neuron.

## Structure
- Package seq_mlp_pkg holds:
  - the weight-code typedef and field widths
  - state enum
  - default model constants W0/B0/W1/B1
  - latency localparam function
- One sub-module, seq_mlp_mac: the shift-add accumulator plus ReLU/quantise. Its ports are op, sign, shift, operand and acc.

## Test plan
- Test model: all weights +1 (shift 0), biases 0. in_data all 4'hF. Hidden values: 120>>3 = 15 each. Output values: 45 each. Required result: out_class=0, out_score=45, out_valid at cycle 49.
- Same model with B1={0,0,1}: out_class=2, out_score=46.
- Test model with all hidden weights −1 and zero biases, any input: all hidden=0, outputs 0 → out_class=0, out_score=0.
- Outputs {0x0010,0x00FF,0x0001} via B1 with W1 zero:
  - APPROX_ARGMAX_EN defined, mask 16'h0500: all masked values equal → out_class=0.
  - Undefined: out_class=1.
- Hold out_ready=0 for 20 cycles after out_valid: output is stable and in_ready=0. Pulse out_ready: IDLE is entered next cycle, and a back-to-back vector is accepted.
- Assert rst_n=0 at cycle 20 of a computation: all outputs reset the next edge. A new vector then completes with the correct result.
